// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the fetch PC and sequences every PC change.
// Sources are sequential +4, ID-stage jumps and EX-stage taken branches.
// It also holds a redirect while instruction memory is not ready, and it
// drives the IF/ID and ID/EX flushes.
// Optional feature macro: REDIRECT_CNT_EN adds saturating redirect and
// pending-cycle performance counters. When the macro is undefined, both
// counter ports are tied to 0.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 imemReady,
  input  logic                 stall,
  input  logic                 jumpValid,
  input  logic [31:0]          jumpTarget,
  input  logic                 branchTaken,
  input  logic [31:0]          branchTarget,
  output logic [31:0]          pc,
  output logic                 flushIFID,
  output logic                 flushIDEX,
  output logic                 redirectPending,
  output logic [CNT_WIDTH-1:0] redirectCount,
  output logic [CNT_WIDTH-1:0] pendCycleCount
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_is_branch_q, pend_is_branch_d;
  logic        flush_ifid, flush_idex, redirect_apply;

  // Fetch addresses are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // State, PC and captured-redirect registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q          <= IDLE;
      pc_q             <= word_align(RESET_VECTOR);
      pend_target_q    <= 32'h0;
      pend_is_branch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pend_target_q    <= pend_target_d;
      pend_is_branch_q <= pend_is_branch_d;
    end
  end

  // Request arbitration, next PC and flush generation.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pend_target_d    = pend_target_q;
    pend_is_branch_d = pend_is_branch_q;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    redirect_apply   = 1'b0;
    case (state_q)
      IDLE: begin
        if (branchTaken) begin
          // The branch is older; any same-cycle jump is wrong-path.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (imemReady) begin
            pc_d           = word_align(branchTarget);
            redirect_apply = 1'b1;
          end else begin
            state_d          = PENDING;
            pend_target_d    = word_align(branchTarget);
            pend_is_branch_d = 1'b1;
          end
        end else if (jumpValid && !stall) begin
          flush_ifid = 1'b1;
          if (imemReady) begin
            pc_d           = word_align(jumpTarget);
            redirect_apply = 1'b1;
          end else begin
            state_d          = PENDING;
            pend_target_d    = word_align(jumpTarget);
            pend_is_branch_d = 1'b0;
          end
        end else if (imemReady && !stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PENDING: begin
        // Every fetch made while waiting is wrong-path.
        flush_ifid = 1'b1;
        if (branchTaken && !pend_is_branch_q) begin
          // An EX branch is older than a held jump, so it takes over.
          flush_idex       = 1'b1;
          pend_target_d    = word_align(branchTarget);
          pend_is_branch_d = 1'b1;
        end
        if (imemReady) begin
          pc_d             = pend_target_d;
          state_d          = IDLE;
          pend_is_branch_d = 1'b0;
          redirect_apply   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc              = pc_q;
  assign flushIFID       = flush_ifid & ~Reset;
  assign flushIDEX       = flush_idex & ~Reset;
  assign redirectPending = (state_q == PENDING);

`ifdef REDIRECT_CNT_EN
  logic [CNT_WIDTH-1:0] redir_cnt_q, pend_cnt_q;

  // Saturating performance counters for applied redirects and pending cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      redir_cnt_q <= '0;
      pend_cnt_q  <= '0;
    end else begin
      if (redirect_apply && (redir_cnt_q != '1))
        redir_cnt_q <= redir_cnt_q + 1'b1;
      if ((state_q == PENDING) && (pend_cnt_q != '1))
        pend_cnt_q <= pend_cnt_q + 1'b1;
    end
  end

  assign redirectCount  = redir_cnt_q;
  assign pendCycleCount = pend_cnt_q;
`else
  logic unused_apply;
  assign unused_apply   = redirect_apply;
  assign redirectCount  = '0;
  assign pendCycleCount = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl.
// The stimulus pushes hand-computed expectations for each cycle.
// The negedge monitor pops each expectation and compares it.
module tb_pc_redirect_ctrl;

`ifdef REDIRECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        imemReady = 1'b0, stall = 1'b0;
  logic        jumpValid = 1'b0, branchTaken = 1'b0;
  logic [31:0] jumpTarget = 32'h0, branchTarget = 32'h0;
  logic [31:0] pc;
  logic        flushIFID, flushIDEX, redirectPending;
  logic [15:0] redirectCount, pendCycleCount;

  pc_redirect_ctrl #(.RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .imemReady(imemReady), .stall(stall),
    .jumpValid(jumpValid), .jumpTarget(jumpTarget),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .pc(pc), .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .redirectPending(redirectPending),
    .redirectCount(redirectCount), .pendCycleCount(pendCycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        fi, fe, pd;
    bit          cc;
    logic [31:0] rc, pcc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s: got %h want %h", id, nm, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents pc and flags; compare against the queue.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.id, "pc", pc, e.pc);
      chk(e.id, "flushIFID", {31'b0, flushIFID}, {31'b0, e.fi});
      chk(e.id, "flushIDEX", {31'b0, flushIDEX}, {31'b0, e.fe});
      chk(e.id, "redirectPending", {31'b0, redirectPending}, {31'b0, e.pd});
      if (e.cc) begin
        chk(e.id, "redirectCount", {16'b0, redirectCount}, e.rc);
        chk(e.id, "pendCycleCount", {16'b0, pendCycleCount}, e.pcc);
      end
    end
  end

  task automatic step(input int id, input logic rs, rdy, stl, jv, input logic [31:0] jt,
                      input logic bt, input logic [31:0] btg,
                      input logic [31:0] epc, input logic efi, efe, epd,
                      input bit cc, input logic [31:0] erc, epcc);
    exp_t e;
    Reset = rs; imemReady = rdy; stall = stl;
    jumpValid = jv; jumpTarget = jt; branchTaken = bt; branchTarget = btg;
    e.id = id; e.pc = epc; e.fi = efi; e.fe = efe; e.pd = epd;
    e.cc = cc; e.rc = CNT_EN ? erc : 32'h0; e.pcc = CNT_EN ? epcc : 32'h0;
    sb.push_back(e);
    @(posedge Clk); #1;
  endtask

  initial begin
    @(posedge Clk); #1;
    // Reset state
    step( 1, 1,0,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 1,0,0);
    // Sequential fetch 0 -> 4 -> 8 -> C -> 10
    step( 2, 0,1,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 0,0,0);
    step( 3, 0,1,0,0,32'h0,        0,32'h0,   32'h4,        0,0,0, 0,0,0);
    step( 4, 0,1,0,0,32'h0,        0,32'h0,   32'h8,        0,0,0, 0,0,0);
    step( 5, 0,1,0,0,32'h0,        0,32'h0,   32'hC,        0,0,0, 0,0,0);
    // Jump at pc 0x10
    step( 6, 0,1,0,1,32'h0040_0100,0,32'h0,   32'h10,       1,0,0, 0,0,0);
    step( 7, 0,0,0,0,32'h0,        0,32'h0,   32'h0040_0100,0,0,0, 0,0,0);
    // Branch beats jump
    step( 8, 0,1,0,1,32'h300,      1,32'h200, 32'h0040_0100,1,1,0, 0,0,0);
    step( 9, 0,0,0,0,32'h0,        0,32'h0,   32'h200,      0,0,0, 0,0,0);
    // Jump under stall is ignored, then captured
    step(10, 0,1,1,1,32'h400,      0,32'h0,   32'h200,      0,0,0, 0,0,0);
    step(11, 0,1,1,1,32'h400,      0,32'h0,   32'h200,      0,0,0, 0,0,0);
    step(12, 0,1,0,1,32'h400,      0,32'h0,   32'h200,      1,0,0, 0,0,0);
    step(13, 0,0,0,0,32'h0,        0,32'h0,   32'h400,      0,0,0, 0,0,0);
    // Async reset away from a clock edge
    step(14, 1,0,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 1,0,0);
    step(15, 0,0,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 0,0,0);
    // Branch held for three not-ready cycles
    step(16, 0,0,0,0,32'h0,        1,32'h80,  32'h0,        1,1,0, 0,0,0);
    step(17, 0,0,0,0,32'h0,        0,32'h0,   32'h0,        1,0,1, 0,0,0);
    step(18, 0,0,0,0,32'h0,        0,32'h0,   32'h0,        1,0,1, 0,0,0);
    step(19, 0,1,0,0,32'h0,        0,32'h0,   32'h0,        1,0,1, 0,0,0);
    step(20, 0,0,0,0,32'h0,        0,32'h0,   32'h80,       0,0,0, 1,1,3);
    // Pending jump overridden by a branch; later requests ignored
    step(21, 0,0,0,1,32'h500,      0,32'h0,   32'h80,       1,0,0, 0,0,0);
    step(22, 0,0,0,0,32'h0,        1,32'h600, 32'h80,       1,1,1, 0,0,0);
    step(23, 0,0,0,1,32'h700,      0,32'h0,   32'h80,       1,0,1, 0,0,0);
    step(24, 0,0,0,0,32'h0,        1,32'h900, 32'h80,       1,0,1, 0,0,0);
    step(25, 0,1,1,0,32'h0,        0,32'h0,   32'h80,       1,0,1, 0,0,0);
    step(26, 0,0,0,0,32'h0,        0,32'h0,   32'h600,      0,0,0, 1,2,7);
    // Reset mid-PENDING with a held branch to 0x80
    step(27, 0,0,0,0,32'h0,        1,32'h80,  32'h600,      1,1,0, 0,0,0);
    step(28, 0,0,0,0,32'h0,        0,32'h0,   32'h600,      1,0,1, 0,0,0);
    step(29, 1,1,0,0,32'h0,        1,32'h80,  32'h0,        0,0,0, 1,0,0);
    step(30, 0,1,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 0,0,0);
    // Misaligned jump target and wrap from the top of the address space
    step(31, 0,1,0,1,32'hFFFF_FFFF,0,32'h0,   32'h4,        1,0,0, 0,0,0);
    step(32, 0,1,0,0,32'h0,        0,32'h0,   32'hFFFF_FFFC,0,0,0, 0,0,0);
    step(33, 0,1,0,0,32'h0,        0,32'h0,   32'h0,        0,0,0, 0,0,0);
    step(34, 0,1,1,0,32'h0,        0,32'h0,   32'h4,        0,0,0, 0,0,0);
    step(35, 0,0,0,0,32'h0,        0,32'h0,   32'h4,        0,0,0, 1,1,0);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
